nrzi_rx_deser: RTL and testbench
================================

# nrzi_rx_deser

NRZI receive stage that sits directly downstream of the NRZI line encoder. It samples the line on a bit strobe and recovers data bits from level transitions. It removes stuffed zeros after runs of ones, deserialises the bit stream LSB-first into words, and presents each word on a one-entry valid/ready output buffer. Stuffing violations and output overruns are flagged to the link controller.

## Interface
- DATA_W, 8, output word width in bits (2..32)
- STUFF_LEN, 6, run of consecutive decoded 1s after which one stuffed 0 is expected; 0 disables unstuffing
- MARK_ONE, 1, 1: line toggle decodes as 1 and no toggle as 0; 0: inverted (toggle = 0)
- clk_i  in  1  clock; all logic on rising edge
- resetn_i  in  1  reset, asynchronous, active-low
- line_i  in  1  NRZI line level, synchronous to clk_i
- bit_en_i  in  1  bit strobe; line_i is sampled only in cycles where this is 1
- flush_i  in  1  clears the receive pipeline (resync)
- ready_i  in  1  consumer accepts data_o
- data_o  out  DATA_W  received word, bit 0 = first received bit
- valid_o  out  1  data_o holds an unconsumed word
- overflow_o  out  1  one-cycle pulse: completed word dropped
- stuff_err_o  out  1  sticky stuffing violation

## Operation
- Registers: prev_lvl, shift (DATA_W), bit_cnt (0..DATA_W-1), ones_cnt (0..STUFF_LEN), out_buf, valid, FSM state {S_RUN, S_ERR}.
- Reset values: prev_lvl=0 (matches encoder reset level), shift=0, bit_cnt=0, ones_cnt=0, state=S_RUN, data_o=0, valid_o=0, overflow_o=0, stuff_err_o=0.
- Decode, on bit_en_i=1 in S_RUN: raw = line_i ^ prev_lvl; bit = MARK_ONE ? raw : ~raw; prev_lvl <= line_i.
- Unstuff, with STUFF_LEN>0:
  - ones_cnt==STUFF_LEN and bit==0: stuffed bit; drop it, set ones_cnt=0, leave bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and bit==1: violation; set stuff_err_o=1, go to S_ERR, discard the partial word (bit_cnt=0).
  - Otherwise: data bit; ones_cnt = bit ? ones_cnt+1 : 0.
  - ones_cnt persists across word boundaries.
- Data bit: shift[bit_cnt] <= bit.
  - bit_cnt==DATA_W-1: word completes and bit_cnt wraps to 0.
  - Otherwise bit_cnt increments.
- Word completion, assembled word = shift with the current bit inserted:
  - valid_o=0, or valid_o=1 with ready_i=1: load out_buf, valid_o=1.
  - valid_o=1 with ready_i=0: drop the new word, keep out_buf, pulse overflow_o for one cycle.
- Handshake: a word transfers when valid_o & ready_i. valid_o then clears unless a completion occurs in the same cycle. data_o is stable while valid_o=1 and ready_i=0.
- S_ERR: bit_en_i is ignored, but prev_lvl still tracks line_i on each strobe. The output buffer still drains normally. Only flush_i or reset leaves S_ERR.
- flush_i=1 (has priority over bit_en_i in the same cycle):
  - Sets bit_cnt=0, ones_cnt=0, shift=0, stuff_err_o=0, state=S_RUN, prev_lvl<=line_i.
  - Does not alter out_buf or valid_o.
- A reset mid-word discards all state. No partial word is ever output.

## Timing
- Latency: valid_o and data_o update on the clock edge that samples the final bit_en_i of a word. They are visible the cycle after that strobe cycle.
- stuff_err_o and overflow_o assert on the same edge as the event.
- A completion is possible on every bit_en_i; back-to-back strobes (bit_en_i tied high) are fully supported.
- ready_i is combinationally unused for valid_o; there is no combinational path from any input to any output.

## Test plan
- Reset, DATA_W=8, STUFF_LEN=6, MARK_ONE=1; line_i = 1,1,0,0,0,1,1,0 on 8 consecutive strobes, ready_i=1 -> data_o=0xA5, valid_o=1 for exactly one cycle after the 8th strobe.
- Encoded 0xFF with one stuffed 0 after the 6th one (9 strobes, line 1,0,1,0,1,0,0,1,0) -> data_o=0xFF, no stuff_err_o, next word decodes correctly with ones_cnt starting at 2.
- 7 consecutive decoded 1s -> stuff_err_o=1 after the 7th strobe, no valid_o; further strobes ignored; flush_i pulse -> stuff_err_o=0, next 8-bit word 0x3C decodes correctly.
- ready_i=0, two words 0x12 then 0x34 -> data_o stays 0x12, overflow_o one-cycle pulse at the second completion; ready_i=1 -> 0x12 transfers, valid_o=0.
- ready_i=1 in the same cycle a second word completes -> 0x12 consumed, data_o=0x34, valid_o stays 1, no overflow_o.
- Reset asserted after 4 bits of a word -> all outputs 0 asynchronously; after release, 8 fresh bits encoding 0x5A -> data_o=0x5A.

Source files
------------

// File: rtl/nrzi_rx_deser.sv
// rtl/nrzi_rx_deser.sv - NRZI receive decoder with zero-unstuffing and LSB-first deserialiser
module nrzi_rx_deser #(
    parameter int DATA_W    = 8,
    parameter int STUFF_LEN = 6,
    parameter int MARK_ONE  = 1
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              line_i,
    input  logic              bit_en_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overflow_o,
    output logic              stuff_err_o
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int ONES_W = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    typedef enum logic {
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q;
    logic                prev_lvl_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [ONES_W-1:0]   ones_cnt_q;
    logic [DATA_W-1:0]   out_buf_q;
    logic                valid_q;
    logic                overflow_q;
    logic                stuff_err_q;

    logic                raw_bit;
    logic                dec_bit;
    logic                at_stuff;
    logic                word_done;
    logic [DATA_W-1:0]   word_d;

    always_comb begin
        raw_bit   = line_i ^ prev_lvl_q;
        dec_bit   = (MARK_ONE != 0) ? raw_bit : ~raw_bit;
        at_stuff  = (STUFF_LEN > 0) && (ones_cnt_q == ONES_MAX);
        word_done = (bit_cnt_q == LAST_BIT);
        // The final bit is not yet in shift_q; splice it in at the MSB.
        word_d             = shift_q;
        word_d[DATA_W-1]   = dec_bit;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= S_RUN;
            prev_lvl_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ones_cnt_q  <= '0;
            out_buf_q   <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            if (flush_i) begin
                state_q     <= S_RUN;
                prev_lvl_q  <= line_i;
                shift_q     <= '0;
                bit_cnt_q   <= '0;
                ones_cnt_q  <= '0;
                stuff_err_q <= 1'b0;
            end else if (bit_en_i) begin
                // Level history is kept even in S_ERR so a later flush resyncs cleanly.
                prev_lvl_q <= line_i;
                if (state_q == S_RUN) begin
                    if (at_stuff) begin
                        if (!dec_bit) begin
                            ones_cnt_q <= '0;
                        end else begin
                            stuff_err_q <= 1'b1;
                            state_q     <= S_ERR;
                            bit_cnt_q   <= '0;
                        end
                    end else begin
                        if (STUFF_LEN > 0) begin
                            ones_cnt_q <= dec_bit ? ones_cnt_q + 1'b1 : '0;
                        end
                        shift_q[bit_cnt_q] <= dec_bit;
                        if (word_done) begin
                            bit_cnt_q <= '0;
                            if (!valid_q || ready_i) begin
                                out_buf_q <= word_d;
                                valid_q   <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign data_o      = out_buf_q;
    assign valid_o     = valid_q;
    assign overflow_o  = overflow_q;
    assign stuff_err_o = stuff_err_q;

endmodule

// File: tb/tb_nrzi_rx_deser.sv
// tb/tb_nrzi_rx_deser.sv - scoreboard bench for nrzi_rx_deser with a behavioural line encoder
module tb_nrzi_rx_deser;

    logic       clk_i    = 1'b0;
    logic       resetn_i = 1'b0;
    logic       line_i   = 1'b0;
    logic       bit_en_i = 1'b0;
    logic       flush_i  = 1'b0;
    logic       ready_i  = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       overflow_o;
    logic       stuff_err_o;

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         ovf_seen = 0;
    int         ovf_exp  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // Encoder-side view of the line: current level and run of ones sent.
    logic       tb_lvl   = 1'b0;
    int         enc_ones = 0;

    nrzi_rx_deser #(.DATA_W(8), .STUFF_LEN(6), .MARK_ONE(1)) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .line_i      (line_i),
        .bit_en_i    (bit_en_i),
        .flush_i     (flush_i),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o),
        .stuff_err_o (stuff_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every handshake seen mid-cycle pops one expected word.
    always @(negedge clk_i) begin
        if (resetn_i === 1'b1) begin
            if (overflow_o === 1'b1) ovf_seen++;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL word_unexpected: got 0x%0h required no word", data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", {24'd0, data_o}, {24'd0, mon_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic lvl);
        line_i   = lvl;
        bit_en_i = 1'b1;
        tick();
        bit_en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit_en_i = 1'b0;
            line_i   = 1'($urandom);
            tick();
        end
    endtask

    task automatic do_flush();
        line_i   = tb_lvl;
        flush_i  = 1'b1;
        tick();
        flush_i  = 1'b0;
        enc_ones = 0;
    endtask

    // Encode a word LSB-first: a 1 toggles the line, a stuffed 0 follows every run of six 1s.
    task automatic send_word(input logic [7:0] w, input bit rdy_last, input bit gaps);
        bit lv[$];
        int last_idx;
        logic l;
        l = tb_lvl;
        last_idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) l = ~l;
            lv.push_back(l);
            if (i == 7) last_idx = lv.size() - 1;
            enc_ones = w[i] ? enc_ones + 1 : 0;
            if (enc_ones == 6) begin
                lv.push_back(l);
                enc_ones = 0;
            end
        end
        tb_lvl = l;
        for (int k = 0; k < lv.size(); k++) begin
            if (gaps) begin
                ready_i = 1'($urandom);
                idle($urandom_range(0, 2));
                ready_i = 1'($urandom);
            end
            if (rdy_last && k == last_idx) ready_i = 1'b1;
            strobe(lv[k]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic [7:0] t1_lines;
        logic [8:0] t2_lines;

        // Reset state
        tick(); tick();
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst_err", {31'd0, stuff_err_o}, 32'd0);
        resetn_i = 1'b1;
        tick();

        // Hand-encoded 0xA5
        ready_i  = 1'b1;
        t1_lines = 8'b0110_0011;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) strobe(t1_lines[i]);
        chk("a5_valid", {31'd0, valid_o}, 32'd1);
        chk("a5_data", {24'd0, data_o}, 32'hA5);
        idle(1);
        chk("a5_valid_one_cycle", {31'd0, valid_o}, 32'd0);

        // Hand-encoded 0xFF with one stuffed 0, then a word that stuffs from a carried run of 2
        tb_lvl = 1'b0;
        do_flush();
        t2_lines = 9'b0_1001_0101;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 9; i++) strobe(t2_lines[i]);
        chk("ff_data", {24'd0, data_o}, 32'hFF);
        chk("ff_no_err", {31'd0, stuff_err_o}, 32'd0);
        tb_lvl   = 1'b0;
        enc_ones = 2;
        exp_q.push_back(8'h0F);
        send_word(8'h0F, 1'b0, 1'b0);
        chk("carry_data", {24'd0, data_o}, 32'h0F);
        chk("carry_no_err", {31'd0, stuff_err_o}, 32'd0);
        idle(1);

        // Seven 1s in a row is a stuffing violation
        do_flush();
        for (int i = 0; i < 7; i++) begin
            tb_lvl = ~tb_lvl;
            strobe(tb_lvl);
            if (i == 5) chk("six_ones_ok", {31'd0, stuff_err_o}, 32'd0);
        end
        chk("viol_err", {31'd0, stuff_err_o}, 32'd1);
        chk("viol_no_valid", {31'd0, valid_o}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tb_lvl = 1'($urandom);
            strobe(tb_lvl);
        end
        chk("err_ignores_valid", {31'd0, valid_o}, 32'd0);
        chk("err_sticky", {31'd0, stuff_err_o}, 32'd1);
        do_flush();
        chk("flush_clears_err", {31'd0, stuff_err_o}, 32'd0);
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 1'b0, 1'b0);
        chk("post_flush_data", {24'd0, data_o}, 32'h3C);
        idle(1);

        // Overflow: second word dropped while the first is held
        ready_i = 1'b0;
        exp_q.push_back(8'h12);
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b0);
        ovf_exp++;
        chk("ovf_pulse", {31'd0, overflow_o}, 32'd1);
        chk("ovf_keep_data", {24'd0, data_o}, 32'h12);
        idle(1);
        chk("ovf_one_cycle", {31'd0, overflow_o}, 32'd0);
        chk("ovf_still_valid", {31'd0, valid_o}, 32'd1);
        ready_i = 1'b1;
        idle(1);
        chk("drain_valid", {31'd0, valid_o}, 32'd0);

        // Consume and complete in the same cycle
        ready_i = 1'b0;
        exp_q.push_back(8'h12);
        send_word(8'h12, 1'b0, 1'b0);
        exp_q.push_back(8'h34);
        send_word(8'h34, 1'b1, 1'b0);
        chk("same_cyc_valid", {31'd0, valid_o}, 32'd1);
        chk("same_cyc_data", {24'd0, data_o}, 32'h34);
        chk("same_cyc_no_ovf", {31'd0, overflow_o}, 32'd0);
        idle(1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 4; i++) begin
            tb_lvl = ~tb_lvl;
            strobe(tb_lvl);
        end
        resetn_i = 1'b0;
        #1;
        chk("async_rst_data", {24'd0, data_o}, 32'd0);
        chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("async_rst_err", {31'd0, stuff_err_o}, 32'd0);
        tb_lvl   = 1'b0;
        enc_ones = 0;
        line_i   = 1'b0;
        tick(); tick();
        resetn_i = 1'b1;
        tick();
        exp_q.push_back(8'h5A);
        send_word(8'h5A, 1'b1, 1'b0);
        chk("post_rst_data", {24'd0, data_o}, 32'h5A);
        idle(1);

        // Randomised words with strobe gaps and random consumer stalls
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       w = 8'hFF;
                1:       w = 8'hFE;
                default: w = 8'($urandom);
            endcase
            exp_q.push_back(w);
            send_word(w, 1'b1, 1'b1);
        end
        ready_i = 1'b1;
        idle(4);

        chk("queue_drained", exp_q.size(), 32'd0);
        chk("ovf_count", ovf_seen, ovf_exp);
        chk("final_no_err", {31'd0, stuff_err_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
